// File: rtl/sccb_wr_master.sv
// rtl/sccb_wr_master.sv - SCCB write-only master behind AXI-lite style write channels
// Optional NACK abort is enabled by defining SCCB_NACK_CHECK_EN.
module sccb_wr_master #(
    parameter int CLK_FREQ = 74_250_000,
    parameter int SCL_FREQ = 400_000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [6:0]  slave_addr_i,
    input  logic        awvalid_i,
    output logic        awready_o,
    input  logic [15:0] awaddr_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    input  logic [7:0]  wdata_i,
    output logic        bvalid_o,
    input  logic        bready_i,
    output logic [1:0]  bresp_o,
    output logic        scl_o,
    output logic        sda_o,
    input  logic        sda_i
);

    localparam int QTR_RAW = CLK_FREQ / (4 * SCL_FREQ);
    localparam int QTR     = (QTR_RAW < 1) ? 1 : QTR_RAW;
    localparam int CW      = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [CW-1:0] QTR_LAST = CW'(QTR - 1);

`ifdef SCCB_NACK_CHECK_EN
    localparam bit NACK_CHECK = 1'b1;
`else
    localparam bit NACK_CHECK = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] qcnt;
    logic [1:0]    phase;
    logic [2:0]    bit_cnt;
    logic [1:0]    byte_idx;
    logic [6:0]    slave_q;
    logic [15:0]   addr_q;
    logic [7:0]    data_q;
    logic [7:0]    tx_byte;
    logic          nack;
    logic          tick;
    logic          bit_end;
    logic          scl_hi;
    logic          accept;
    logic          abort;

    assign tick    = (qcnt == QTR_LAST);
    assign bit_end = tick && (phase == 2'd3);
    assign scl_hi  = (phase == 2'd1) || (phase == 2'd2);
    assign accept  = (state == S_IDLE) && awvalid_i && wvalid_i;
    assign abort   = NACK_CHECK && nack;

    always_comb begin
        tx_byte = data_q;
        case (byte_idx)
            2'd0:    tx_byte = {slave_q, 1'b0};
            2'd1:    tx_byte = addr_q[15:8];
            2'd2:    tx_byte = addr_q[7:0];
            default: tx_byte = data_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n   = state;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        scl_o     = 1'b1;
        sda_o     = 1'b1;
        case (state)
            S_IDLE: begin
                awready_o = accept;
                wready_o  = accept;
                if (accept) state_n = S_START;
            end
            S_START: begin
                sda_o = (phase == 2'd0);
                if (tick && phase == 2'd2) state_n = S_BIT;
            end
            S_BIT: begin
                scl_o = scl_hi;
                sda_o = tx_byte[~bit_cnt];
                if (bit_end && bit_cnt == 3'd7) state_n = S_ACK;
            end
            S_ACK: begin
                scl_o = scl_hi;
                if (bit_end) state_n = (abort || byte_idx == 2'd3) ? S_STOP : S_BIT;
            end
            S_STOP: begin
                scl_o = (phase != 2'd0);
                sda_o = phase[1];
                if (bit_end) state_n = S_RESP;
            end
            S_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Quarter timer restarts on every state change so each phase begins aligned.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            qcnt     <= '0;
            phase    <= 2'd0;
            bit_cnt  <= 3'd0;
            byte_idx <= 2'd0;
            nack     <= 1'b0;
            bresp_o  <= 2'b00;
            slave_q  <= 7'd0;
            addr_q   <= 16'd0;
            data_q   <= 8'd0;
        end else begin
            if (state_n != state) begin
                qcnt  <= '0;
                phase <= 2'd0;
            end else if (tick) begin
                qcnt  <= '0;
                phase <= phase + 2'd1;
            end else begin
                qcnt  <= qcnt + CW'(1);
            end
            if (accept) begin
                slave_q  <= slave_addr_i;
                addr_q   <= awaddr_i;
                data_q   <= wdata_i;
                bit_cnt  <= 3'd0;
                byte_idx <= 2'd0;
                nack     <= 1'b0;
                bresp_o  <= 2'b00;
            end
            if (state == S_BIT && bit_end) bit_cnt <= bit_cnt + 3'd1;
            if (state == S_ACK && tick && phase == 2'd2) nack <= sda_i;
            if (state == S_ACK && bit_end) begin
                if (abort)                  bresp_o  <= 2'b10;
                else if (byte_idx != 2'd3)  byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_sccb_wr_master.sv
// tb/tb_sccb_wr_master.sv - bus-level checks of sccb_wr_master against an SCCB line monitor
module tb_sccb_wr_master;

    localparam int PERIOD_EXP = 184;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  slave_addr = 7'd0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [15:0] awaddr = 16'd0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [7:0]  wdata = 8'd0;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [1:0]  bresp;
    logic        scl;
    logic        sda;
    logic        sda_line;
    logic        slave_low = 1'b0;
    logic [3:0]  nack_mask = 4'd0;

    int vectors = 0;
    int miscompares = 0;

    assign sda_line = sda & ~slave_low;

    sccb_wr_master dut (
        .clk_i(clk), .rst_n_i(rst_n), .slave_addr_i(slave_addr),
        .awvalid_i(awvalid), .awready_o(awready), .awaddr_i(awaddr),
        .wvalid_i(wvalid), .wready_o(wready), .wdata_i(wdata),
        .bvalid_o(bvalid), .bready_i(bready), .bresp_o(bresp),
        .scl_o(scl), .sda_o(sda), .sda_i(sda_line)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor and ACKing slave: decodes START/STOP, bytes and SCL timing from the pins.
    logic [7:0] got[$];
    logic [7:0] cur = 8'd0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int bitpos = 0, rises = 0, stops = 0, bad_period = 0, last_rise = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            bitpos = 0;
            last_rise = -1;
            slave_low = 1'b0;
        end else begin
            if (prev_scl && scl && prev_sda && !sda_line) begin
                got.delete();
                bitpos = 0;
                rises = 0;
                last_rise = -1;
            end else if (prev_scl && scl && !prev_sda && sda_line) begin
                stops++;
            end
            if (!prev_scl && scl) begin
                rises++;
                if (last_rise >= 0 && cyc - last_rise != PERIOD_EXP) bad_period++;
                last_rise = cyc;
                if (bitpos < 8) begin
                    cur = {cur[6:0], sda_line};
                    bitpos++;
                    if (bitpos == 8) got.push_back(cur);
                end else if (bitpos == 8) begin
                    bitpos = 9;
                end
            end
            if (prev_scl && !scl) begin
                if (bitpos == 8 && got.size() > 0) slave_low = !nack_mask[got.size() - 1];
                else if (bitpos == 9) begin
                    bitpos = 0;
                    slave_low = 1'b0;
                end
            end
        end
        prev_scl = scl;
        prev_sda = sda_line;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input logic [6:0] sa, input logic [15:0] a, input logic [7:0] d,
                           input logic [3:0] nm, input int pre, input int hold);
        int stops0, nb, t;
        logic [7:0] exp_b[4];
        logic err, seen_rdy, seen_low, seen_drop;
        nack_mask = nm;
        stops0 = stops;
        @(negedge clk);
        slave_addr = sa; awaddr = a; wdata = d;
        awvalid = 1'b1;
        wvalid = (pre == 0);
        if (pre > 0) begin
            seen_rdy = 1'b0;
            seen_low = 1'b0;
            repeat (pre) begin
                #1;
                if (awready || wready) seen_rdy = 1'b1;
                if (!scl) seen_low = 1'b1;
                @(negedge clk);
            end
            chk("lone_aw_ready", {31'd0, seen_rdy}, 0);
            chk("lone_aw_scl_low", {31'd0, seen_low}, 0);
            wvalid = 1'b1;
        end
        #1;
        chk("awready", {31'd0, awready}, 1);
        chk("wready", {31'd0, wready}, 1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        t = 0;
        while (!bvalid && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk("bvalid_timeout", {31'd0, bvalid}, 1);

        exp_b[0] = {sa, 1'b0};
        exp_b[1] = a[15:8];
        exp_b[2] = a[7:0];
        exp_b[3] = d;
        nb = 4;
        err = 1'b0;
`ifdef SCCB_NACK_CHECK_EN
        for (int k = 0; k < 4; k++)
            if (nm[k] && !err) begin
                nb = k + 1;
                err = 1'b1;
            end
`endif
        chk("byte_count", got.size(), nb);
        for (int k = 0; k < nb && k < got.size(); k++)
            chk($sformatf("byte%0d", k), {24'd0, got[k]}, {24'd0, exp_b[k]});
        chk("scl_rises", rises, 9 * nb + 1);
        chk("stop_seen", stops - stops0, 1);
        chk("scl_period", bad_period, 0);
        chk("bresp", {30'd0, bresp}, err ? 32'd2 : 32'd0);

        seen_rdy = 1'b0;
        seen_drop = 1'b0;
        awvalid = 1'b1;
        wvalid = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            #1;
            if (awready || wready) seen_rdy = 1'b1;
            if (!bvalid) seen_drop = 1'b1;
        end
        chk("resp_hold_ready", {31'd0, seen_rdy}, 0);
        chk("resp_hold_bvalid_drop", {31'd0, seen_drop}, 0);
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        bready = 1'b1;
        @(posedge clk);
        #1;
        chk("bvalid_release", {31'd0, bvalid}, 0);
        bready = 1'b0;
    endtask

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", {31'd0, scl}, 1);
        chk("rst_sda", {31'd0, sda}, 1);
        chk("rst_bvalid", {31'd0, bvalid}, 0);
        chk("rst_bresp", {30'd0, bresp}, 0);
        chk("rst_awready", {31'd0, awready}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_xfer(7'h1a, 16'h0136, 8'h18, 4'b0000, 0, 2);
        do_xfer(7'h21, 16'hbeef, 8'h5a, 4'b1111, 0, 1);
        do_xfer(7'h3c, 16'h1234, 8'ha5, 4'b0000, 50, 100);
        for (int i = 0; i < 3; i++)
            do_xfer(7'($urandom), 16'($urandom), 8'($urandom), 4'($urandom), 0, $urandom_range(0, 5));

        @(negedge clk);
        slave_addr = 7'h55; awaddr = 16'h7e81; wdata = 8'hc3;
        awvalid = 1'b1;
        wvalid = 1'b1;
        nack_mask = 4'd0;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        repeat (200) @(negedge clk);
        t = 0;
        while (rises < 13 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("second_byte_reached", {31'd0, rises >= 13}, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_scl", {31'd0, scl}, 1);
        chk("midrst_sda", {31'd0, sda}, 1);
        chk("midrst_bvalid", {31'd0, bvalid}, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("midrst_no_resp", {31'd0, bvalid}, 0);
        do_xfer(7'h1a, 16'h0136, 8'h18, 4'b0000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sccb_wr_master.md
SCCB_WR_MASTER -- requirements
Module: sccb_wr_master

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 74_250_000, giving the clk_i frequency in Hz.
REQ-002 SHALL have parameter SCL_FREQ, default 400_000, giving the target SCL frequency in Hz.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_n_i, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port slave_addr_i, input, 7 bits: 7-bit sensor bus address (e.g. 0x1a).
REQ-006 SHALL have port awvalid_i / awready_o, in/out, 1 bit each: write-address handshake.
REQ-007 SHALL have port awaddr_i, input, 16 bits: sensor register address.
REQ-008 SHALL have port wvalid_i / wready_o, in/out, 1 bit each: write-data handshake.
REQ-009 SHALL have port wdata_i, input, 8 bits: register value.
REQ-010 SHALL have port bvalid_o / bready_i, out/in, 1 bit each: write-response handshake.
REQ-011 SHALL have port bresp_o, output, 2 bits: 2'b00 OKAY, 2'b10 SLVERR.
REQ-012 SHALL have port scl_o, output, 1 bit: 0 = drive SCL low, 1 = release.
REQ-013 SHALL have port sda_o, output, 1 bit: 0 = drive SDA low, 1 = release.
REQ-014 SHALL have port sda_i, input, 1 bit: sampled SDA line level.
REQ-015 SHALL have no read-channel ports; reads are unsupported.

Function
REQ-016 SHALL derive QTR = CLK_FREQ/(4*SCL_FREQ) clk_i cycles per quarter SCL period, using integer division, with a minimum of 1.
REQ-017 SHALL implement the states IDLE, START, BIT, ACK, STOP and RESP.
REQ-018 In IDLE, SHALL assert awready_o and wready_o only in a cycle where awvalid_i and wvalid_i are both 1, capture awaddr_i, wdata_i and slave_addr_i, and move to START the next cycle.
REQ-019 In IDLE with only one of awvalid_i or wvalid_i high, SHALL keep both ready outputs at 0.
REQ-020 START SHALL hold SDA released and SCL released for 1 QTR, then drive SDA low for 2 QTR, then drive SCL low.
REQ-021 SHALL send the byte sequence {slave_addr,0}, awaddr[15:8], awaddr[7:0], wdata, each MSB first.
REQ-022 Each bit SHALL last 4 QTR: SDA updates at the start of Q0 with SCL low, SCL is released for Q1–Q2, and SCL is low for Q3.
REQ-023 ACK SHALL release SDA for one 4-QTR bit time and sample sda_i in the last cycle of Q2.
REQ-024 STOP SHALL drive SDA low with SCL low for 1 QTR, release SCL for 1 QTR, then release SDA and hold 2 QTR before entering RESP.
REQ-025 RESP SHALL assert bvalid_o with bresp_o stable until bready_i is 1, then return to IDLE the next cycle.
REQ-026 While bvalid_o is 1, SHALL hold awready_o and wready_o at 0.
REQ-027 SHALL keep the bit counter at 3 bits and the byte index at 2 bits, with no wrap beyond byte 3.

Reset
REQ-028 With rst_n_i=0 at a clock edge, SHALL set the state to IDLE and set scl_o=1, sda_o=1, bvalid_o=0, bresp_o=2'b00, awready_o=0 and wready_o=0 on that edge.
REQ-029 Reset mid-transfer SHALL abandon the transfer without generating STOP and SHALL produce no response.

Configuration
REQ-030 Macro SCCB_NACK_CHECK_EN: when defined, a sampled sda_i=1 in any ACK SHALL abort the remaining bytes, go directly to STOP, and return bresp_o=2'b10.
REQ-031 When SCCB_NACK_CHECK_EN is undefined, ACK values SHALL be ignored (SCCB don't-care), all four bytes SHALL always be sent, and bresp_o SHALL always be 2'b00.

Verification
REQ-032 Default parameters, slave 0x1a, awaddr 0x0136, wdata 0x18, all ACKs 0 -> SDA bytes 0x34,0x01,0x36,0x18; SCL period 184 clk_i cycles; bresp_o=2'b00.
REQ-033 SCCB_NACK_CHECK_EN defined, sda_i=1 during the first ACK -> STOP follows byte 0x34 with no further SCL pulses, then bvalid_o=1 with bresp_o=2'b10.
REQ-034 SCCB_NACK_CHECK_EN undefined, sda_i=1 at every ACK -> all 4 bytes sent and bresp_o=2'b00.
REQ-035 awvalid_i=1 with wvalid_i=0 for 50 cycles -> awready_o=0 and scl_o=1 throughout; raising wvalid_i -> both ready outputs 1 in that cycle.
REQ-036 bready_i held 0 for 100 cycles after a transfer -> bvalid_o stays 1 and a new request is not accepted.
REQ-037 rst_n_i=0 during the second byte -> scl_o=1, sda_o=1 and bvalid_o=0 after the next edge, and a following request completes correctly.
